// File: rtl/dmp_accumulate.sv
// Sums one partial-pagerank packet per gather thread, then adds BASE_TERM at stream_done.
// Latency: ack one cycle after acceptance, pagerank_final one cycle after stream_done; backpressure: the sender waits for ack before the next packet.
module dmp_accumulate #(
    parameter int          NUM_HW_THREADS = 8,
    parameter int          NODES_IN_GRAPH = 32,
    parameter logic [63:0] BASE_TERM      = 64'd0
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           nextIteration,
    input  logic                           stream_start,
    input  logic                           stream_valid,
    input  logic [NODES_IN_GRAPH-1:0][63:0] pagerank_serial_stream,
    input  logic                           stream_done,
    output logic                           ack,
    output logic [NODES_IN_GRAPH-1:0][63:0] pagerank_final,
    output logic                           final_valid,
    output logic [31:0]                    packet_count,
    output logic                           count_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [NODES_IN_GRAPH-1:0][63:0] acc;
    logic                            done_pend;
    logic                            accept;
    logic                            finalize;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finalize  = 1'b0;
        if (nextIteration) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (stream_start) begin
                        state_nxt = RECV;
                    end
                end
                RECV: begin
                    if (stream_valid) begin
                        accept    = 1'b1;
                        state_nxt = ACK;
                    end else if (stream_done) begin
                        finalize  = 1'b1;
                        state_nxt = DONE;
                    end
                end
                ACK: begin
                    // A done that arrived with the last packet finalizes here, after that packet is summed.
                    if (done_pend) begin
                        finalize  = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        state_nxt = RECV;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    assign ack = (state == ACK);

    always_ff @(posedge clock) begin
        if (!reset_n || nextIteration) begin
            acc            <= '0;
            pagerank_final <= '0;
            final_valid    <= 1'b0;
            packet_count   <= '0;
            count_error    <= 1'b0;
            done_pend      <= 1'b0;
        end else begin
            if (accept) begin
                for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                    acc[i] <= acc[i] + pagerank_serial_stream[i];
                end
                if (packet_count != 32'hFFFF_FFFF) begin
                    packet_count <= packet_count + 32'd1;
                end
                done_pend <= stream_done;
            end
            if (finalize) begin
                for (int i = 0; i < NODES_IN_GRAPH; i++) begin
                    pagerank_final[i] <= acc[i] + BASE_TERM;
                end
                final_valid <= 1'b1;
                count_error <= (packet_count != 32'(NUM_HW_THREADS));
                done_pend   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmp_accumulate.sv
// Directed bench for dmp_accumulate: iteration sums, short stream, valid+done collision, wrap, reset and re-arm.
module tb_dmp_accumulate;

    localparam int NUM   = 8;
    localparam int NODES = 4;

    logic                   clock = 1'b0;
    logic                   reset_n;
    logic                   nextIteration;
    logic                   stream_start;
    logic                   stream_valid;
    logic [NODES-1:0][63:0] stream;
    logic                   stream_done;

    logic                   ack, ack0;
    logic [NODES-1:0][63:0] pfinal, pfinal0;
    logic                   final_valid, final_valid0;
    logic [31:0]            packet_count, packet_count0;
    logic                   count_error, count_error0;

    int total = 0;
    int bad   = 0;
    int ack_hi = 0;
    int ack_pulses = 0;
    logic ack_prev = 1'b0;
    logic [63:0] exp;

    always #5 clock = ~clock;

    dmp_accumulate #(.NUM_HW_THREADS(NUM), .NODES_IN_GRAPH(NODES), .BASE_TERM(64'h10)) u_dut (
        .clock(clock), .reset_n(reset_n), .nextIteration(nextIteration),
        .stream_start(stream_start), .stream_valid(stream_valid),
        .pagerank_serial_stream(stream), .stream_done(stream_done),
        .ack(ack), .pagerank_final(pfinal), .final_valid(final_valid),
        .packet_count(packet_count), .count_error(count_error)
    );

    dmp_accumulate #(.NUM_HW_THREADS(NUM), .NODES_IN_GRAPH(NODES), .BASE_TERM(64'h0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .nextIteration(nextIteration),
        .stream_start(stream_start), .stream_valid(stream_valid),
        .pagerank_serial_stream(stream), .stream_done(stream_done),
        .ack(ack0), .pagerank_final(pfinal0), .final_valid(final_valid0),
        .packet_count(packet_count0), .count_error(count_error0)
    );

    always @(negedge clock) begin
        if (ack) ack_hi++;
        if (ack && !ack_prev) ack_pulses++;
        ack_prev = ack;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rearm();
        nextIteration = 1'b1;
        tick();
        nextIteration = 1'b0;
        stream_start  = 1'b1;
        tick();
        stream_start  = 1'b0;
        ack_hi     = 0;
        ack_pulses = 0;
    endtask

    // Holds valid through the ACK cycle so a second acceptance would show up in packet_count.
    task automatic send_packet(input int t);
        for (int i = 0; i < NODES; i++) stream[i] = 64'(t + i);
        stream_valid = 1'b1;
        tick();
        total++;
        if (ack !== 1'b1) begin
            bad++;
            $display("FAIL ack_after_accept pkt=%0d got=%b want=1", t, ack);
        end
        tick();
        stream_valid = 1'b0;
    endtask

    task automatic pulse_done();
        stream_done = 1'b1;
        tick();
        stream_done = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; nextIteration = 1'b0; stream_start = 1'b0;
        stream_valid = 1'b0; stream_done = 1'b0; stream = '0;
        tick(); tick();
        total++;
        if ({ack, final_valid, count_error} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000", {ack, final_valid, count_error});
        end
        total++;
        if (packet_count !== 32'd0 || pfinal !== '0) begin
            bad++;
            $display("FAIL reset_data count=%0d final=%h want 0", packet_count, pfinal);
        end
        reset_n = 1'b1;
        for (int i = 0; i < NODES; i++) stream[i] = 64'd9;
        stream_valid = 1'b1;
        tick(); tick(); tick();
        stream_valid = 1'b0;
        total++;
        if (packet_count !== 32'd0 || ack_pulses != 0) begin
            bad++;
            $display("FAIL idle_ignores_valid count=%0d acks=%0d want 0/0", packet_count, ack_pulses);
        end
    endtask

    task automatic test_basic();
        rearm();
        for (int t = 0; t < NUM; t++) send_packet(t);
        pulse_done();
        for (int i = 0; i < NODES; i++) begin
            exp = 64'(28 + 8 * i + 16);
            total++;
            if (pfinal[i] !== exp) begin
                bad++;
                $display("FAIL basic_lane%0d got=%0d want=%0d", i, pfinal[i], exp);
            end
        end
        total++;
        if (final_valid !== 1'b1 || count_error !== 1'b0 || packet_count !== 32'd8) begin
            bad++;
            $display("FAIL basic_status fv=%b err=%b cnt=%0d want 1/0/8", final_valid, count_error, packet_count);
        end
        total++;
        if (ack_hi != 8 || ack_pulses != 8) begin
            bad++;
            $display("FAIL basic_acks cycles=%0d pulses=%0d want 8/8", ack_hi, ack_pulses);
        end
        // Held valid in DONE must neither count nor ack, and outputs hold.
        stream_valid = 1'b1;
        tick(); tick(); tick();
        stream_valid = 1'b0;
        total++;
        if (packet_count !== 32'd8 || ack_pulses != 8 || final_valid !== 1'b1 || pfinal[3] !== 64'd68) begin
            bad++;
            $display("FAIL done_hold cnt=%0d acks=%0d fv=%b lane3=%0d want 8/8/1/68", packet_count, ack_pulses, final_valid, pfinal[3]);
        end
        nextIteration = 1'b1;
        tick();
        nextIteration = 1'b0;
        total++;
        if (final_valid !== 1'b0 || packet_count !== 32'd0 || pfinal !== '0 || count_error !== 1'b0) begin
            bad++;
            $display("FAIL next_clear fv=%b cnt=%0d final=%h err=%b want 0", final_valid, packet_count, pfinal, count_error);
        end
    endtask

    task automatic test_short();
        rearm();
        for (int t = 0; t < 5; t++) send_packet(t);
        pulse_done();
        total++;
        if (count_error !== 1'b1 || packet_count !== 32'd5 || final_valid !== 1'b1) begin
            bad++;
            $display("FAIL short_status err=%b cnt=%0d fv=%b want 1/5/1", count_error, packet_count, final_valid);
        end
        total++;
        if (pfinal[0] !== 64'd26 || pfinal[2] !== 64'd36) begin
            bad++;
            $display("FAIL short_sum lane0=%0d lane2=%0d want 26/36", pfinal[0], pfinal[2]);
        end
    endtask

    task automatic test_simul();
        rearm();
        for (int t = 0; t < NUM - 1; t++) send_packet(t);
        for (int i = 0; i < NODES; i++) stream[i] = 64'(7 + i);
        stream_valid = 1'b1;
        stream_done  = 1'b1;
        tick();
        total++;
        if (ack !== 1'b1 || final_valid !== 1'b0) begin
            bad++;
            $display("FAIL simul_ack_cycle ack=%b fv=%b want 1/0", ack, final_valid);
        end
        tick();
        stream_valid = 1'b0;
        stream_done  = 1'b0;
        tick();
        for (int i = 0; i < NODES; i++) begin
            exp = 64'(28 + 8 * i + 16);
            total++;
            if (pfinal[i] !== exp) begin
                bad++;
                $display("FAIL simul_lane%0d got=%0d want=%0d", i, pfinal[i], exp);
            end
        end
        total++;
        if (final_valid !== 1'b1 || count_error !== 1'b0 || packet_count !== 32'd8 || ack_pulses != 8 || ack_hi != 8) begin
            bad++;
            $display("FAIL simul_status fv=%b err=%b cnt=%0d acks=%0d/%0d want 1/0/8/8/8", final_valid, count_error, packet_count, ack_pulses, ack_hi);
        end
    endtask

    task automatic test_wrap();
        rearm();
        stream = '0;
        stream[0] = 64'hFFFF_FFFF_FFFF_FFFF; stream[1] = 64'd5;
        stream_valid = 1'b1; tick(); tick(); stream_valid = 1'b0;
        stream[0] = 64'd2; stream[1] = 64'd7;
        stream_valid = 1'b1; tick(); tick(); stream_valid = 1'b0;
        pulse_done();
        total++;
        if (pfinal0[0] !== 64'd1 || pfinal0[1] !== 64'd12) begin
            bad++;
            $display("FAIL wrap_base0 lane0=%0d lane1=%0d want 1/12", pfinal0[0], pfinal0[1]);
        end
        total++;
        if (pfinal[0] !== 64'd17 || count_error0 !== 1'b1 || packet_count0 !== 32'd2) begin
            bad++;
            $display("FAIL wrap_base16 lane0=%0d err=%b cnt=%0d want 17/1/2", pfinal[0], count_error0, packet_count0);
        end
    endtask

    task automatic test_reset_mid();
        rearm();
        for (int t = 0; t < 2; t++) send_packet(100);
        stream_valid = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        total++;
        if (ack !== 1'b0 || packet_count !== 32'd0 || pfinal !== '0) begin
            bad++;
            $display("FAIL reset_in_ack ack=%b cnt=%0d want 0/0", ack, packet_count);
        end
        reset_n = 1'b1;
        tick(); tick();
        stream_valid = 1'b0;
        total++;
        if (packet_count !== 32'd0 || ack !== 1'b0) begin
            bad++;
            $display("FAIL reset_needs_start cnt=%0d ack=%b want 0/0", packet_count, ack);
        end
        stream_start = 1'b1; tick(); stream_start = 1'b0;
        for (int t = 0; t < NUM; t++) send_packet(t);
        pulse_done();
        for (int i = 0; i < NODES; i++) begin
            exp = 64'(28 + 8 * i + 16);
            total++;
            if (pfinal[i] !== exp) begin
                bad++;
                $display("FAIL after_reset_lane%0d got=%0d want=%0d", i, pfinal[i], exp);
            end
        end
    endtask

    task automatic test_next_priority();
        rearm();
        for (int i = 0; i < NODES; i++) stream[i] = 64'd3;
        stream_valid  = 1'b1;
        nextIteration = 1'b1;
        tick();
        nextIteration = 1'b0;
        tick();
        stream_valid  = 1'b0;
        total++;
        if (packet_count !== 32'd0 || ack_pulses != 0) begin
            bad++;
            $display("FAIL next_over_valid cnt=%0d acks=%0d want 0/0", packet_count, ack_pulses);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_simul();
        test_wrap();
        test_reset_mid();
        test_next_priority();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
